// File: rtl/bpm_period_calc.sv
// Metronome tick period generator: period = NUMER / (bpm * subdivision),
// computed with a radix-2 restoring divider behind a start/valid handshake.
module bpm_period_calc #(
  parameter int              NUM_W = 40,
  parameter int              BPM_W = 34,
  parameter int              OUT_W = 34,
  parameter logic [NUM_W-1:0] NUMER = 40'd12000000000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [BPM_W-1:0] i_bpm_counter,
  input  logic [1:0]       i_subdiv,
  output logic             o_busy,
  output logic             o_valid,
  output logic [OUT_W-1:0] o_period,
  output logic             o_err,
  output logic             o_sat
);

  localparam int CNT_W = $clog2(NUM_W);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t                  state, state_next;
  logic                    capture;
  logic                    pending;
  logic                    err_q;
  logic [NUM_W-1:0]        denom;
  logic [NUM_W:0]          rem;
  logic [NUM_W-1:0]        quo;
  logic [CNT_W-1:0]        cnt;
  logic [BPM_W+1:0]        denom_in;
  logic signed [NUM_W+1:0] trial;
  logic [OUT_W:0]          clamped;

  function automatic logic [BPM_W+1:0] scale_bpm(input logic [BPM_W-1:0] bpm,
                                                 input logic [1:0]       sub);
    logic [BPM_W+1:0] d;
    case (sub)
      2'd0:    d = {2'b00, bpm};
      2'd1:    d = {1'b0, bpm, 1'b0};
      2'd2:    d = {1'b0, bpm, 1'b0} + {2'b00, bpm};
      default: d = {bpm, 2'b00};
    endcase
    return d;
  endfunction

  // Returns {sat, period}: quotients wider than OUT_W clamp to all ones.
  function automatic logic [OUT_W:0] clamp_period(input logic [NUM_W-1:0] q);
    logic sat;
    sat = |(q >> OUT_W);
    return {sat, sat ? {OUT_W{1'b1}} : q[OUT_W-1:0]};
  endfunction

  assign denom_in = scale_bpm(i_bpm_counter, i_subdiv);
  // rem never exceeds denom, so the top bit of {rem, msb} is a clean sign bit.
  assign trial    = $signed({rem, quo[NUM_W-1]}) - $signed({2'b00, denom});
  assign clamped  = clamp_period(quo);
  assign o_busy   = (state != IDLE);

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (i_start || pending) begin
          capture    = 1'b1;
          state_next = (denom_in == '0) ? DONE : DIV;
        end
      end
      DIV:     if (cnt == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= IDLE;
      pending  <= 1'b0;
      err_q    <= 1'b0;
      denom    <= '0;
      rem      <= '0;
      quo      <= '0;
      cnt      <= '0;
      o_valid  <= 1'b0;
      o_period <= '0;
      o_err    <= 1'b0;
      o_sat    <= 1'b0;
    end else begin
      state   <= state_next;
      o_valid <= 1'b0;

      if (i_start && (state != IDLE))
        pending <= 1'b1;
      else if (capture)
        pending <= 1'b0;

      if (capture) begin
        denom <= NUM_W'(denom_in);
        rem   <= '0;
        quo   <= (denom_in == '0) ? '0 : NUMER;
        cnt   <= CNT_W'(NUM_W - 1);
        err_q <= (denom_in == '0);
      end

      if (state == DIV) begin
        quo <= {quo[NUM_W-2:0], ~trial[NUM_W+1]};
        rem <= trial[NUM_W+1] ? {rem[NUM_W-1:0], quo[NUM_W-1]} : trial[NUM_W:0];
        cnt <= cnt - 1'b1;
      end

      if (state == DONE) begin
        o_valid <= 1'b1;
        if (err_q) begin
          o_period <= '0;
          o_err    <= 1'b1;
          o_sat    <= 1'b0;
        end else begin
          o_period <= clamped[OUT_W-1:0];
          o_err    <= 1'b0;
          o_sat    <= clamped[OUT_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_bpm_period_calc.sv
// Directed bench for bpm_period_calc: default instance plus a 24-bit-output
// instance sharing the same stimulus for the saturation cases.
module tb_bpm_period_calc;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [33:0] bpm;
  logic [1:0]  sub;

  logic        busy, v, err, sat;
  logic [33:0] period;
  logic        busy_s, v_s, err_s, sat_s;
  logic [23:0] period_s;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  bpm_period_calc dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_bpm_counter(bpm),
    .i_subdiv(sub), .o_busy(busy), .o_valid(v), .o_period(period),
    .o_err(err), .o_sat(sat)
  );

  bpm_period_calc #(.OUT_W(24)) dut_s (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_bpm_counter(bpm),
    .i_subdiv(sub), .o_busy(busy_s), .o_valid(v_s), .o_period(period_s),
    .o_err(err_s), .o_sat(sat_s)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_pulse(input logic [33:0] b, input logic [1:0] s);
    @(posedge clk); #1;
    bpm = b; sub = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Starts one request and waits for o_valid; leaves the bench one cycle
  // past the valid pulse with outputs held.
  task automatic run_one(input logic [33:0] b, input logic [1:0] s,
                         input int exp_lat, input string tag);
    int  lat;
    bit  ok;
    lat = -1;
    ok  = 1'b0;
    start_pulse(b, s);
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (i == 0 && exp_lat > 1) check({tag, "_busy_first"}, busy, 1);
      if (i == exp_lat - 1) check({tag, "_busy_done"}, busy, 1);
      if (v) begin
        ok  = 1'b1;
        lat = i;
        check({tag, "_valid_s"}, v_s, 1);
      end
    end
    check({tag, "_latency"}, ok ? lat : 999, exp_lat);
    @(negedge clk);
    check({tag, "_one_pulse"}, v, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int nv, t0, t1;
    logic [33:0] p0, p1;

    rst = 1'b1; start = 1'b0; bpm = '0; sub = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_period", period, 0);
    check("rst_valid", v, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_sat", sat, 0);
    check("rst_period_s", period_s, 0);

    run_one(34'd120, 2'd0, 41, "bpm120");
    check("bpm120_period", period, 64'd100000000);
    check("bpm120_err", err, 0);
    check("bpm120_sat", sat, 0);

    bpm = 34'd77; sub = 2'd3;
    repeat (5) @(negedge clk);
    check("hold_period", period, 64'd100000000);
    check("hold_busy", busy, 0);

    run_one(34'd120, 2'd3, 41, "bpm120x4");
    check("bpm120x4_period", period, 64'd25000000);

    run_one(34'd100, 2'd2, 41, "bpm100x3");
    check("bpm100x3_period", period, 64'd40000000);

    run_one(34'd1, 2'd0, 41, "bpm1");
    check("bpm1_period", period, 64'd12000000000);
    check("bpm1_sat", sat, 0);
    check("bpm1_period_s", period_s, 64'hFFFFFF);
    check("bpm1_sat_s", sat_s, 1);

    run_one(34'd1000, 2'd0, 41, "bpm1000");
    check("bpm1000_period", period, 64'd12000000);
    check("bpm1000_period_s", period_s, 64'd12000000);
    check("bpm1000_sat_s", sat_s, 0);
    check("bpm1000_err_s", err_s, 0);

    run_one(34'd0, 2'd2, 1, "zero");
    check("zero_period", period, 0);
    check("zero_err", err, 1);
    check("zero_sat", sat, 0);

    run_one(34'd60, 2'd0, 41, "bpm60");
    check("bpm60_period", period, 64'd200000000);
    check("bpm60_err", err, 0);

    // Live BPM change: two starts while busy collapse into one restart.
    nv = 0; t0 = -1; t1 = -1; p0 = '0; p1 = '0;
    @(posedge clk); #1;
    bpm = 34'd120; sub = 2'd0; start = 1'b1;
    for (int c = 0; c < 150; c++) begin
      @(posedge clk); #1;
      start = (c == 10 || c == 12);
      if (c == 10) bpm = 34'd240;
      @(negedge clk);
      if (v) begin
        if (nv == 0) begin t0 = c; p0 = period; end
        else if (nv == 1) begin t1 = c; p1 = period; end
        nv++;
      end
    end
    check("pend_count", nv, 2);
    check("pend_first_lat", t0, 41);
    check("pend_first_period", p0, 64'd100000000);
    check("pend_gap", t1 - t0, 42);
    check("pend_second_period", p1, 64'd50000000);

    // Reset in the middle of a division.
    nv = 0;
    @(posedge clk); #1;
    bpm = 34'd120; sub = 2'd0; start = 1'b1;
    for (int c = 0; c < 120; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      rst   = (c == 19);
      @(negedge clk);
      if (c == 20) begin
        check("mid_rst_period", period, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", v, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_sat", sat, 0);
      end
      if (v) nv++;
    end
    check("mid_rst_no_valid", nv, 0);

    run_one(34'd240, 2'd1, 41, "after_rst");
    check("after_rst_period", period, 64'd25000000);
    check("after_rst_err", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
